mem_port_arbiter: RTL and testbench

//  Shares one pipelined Avalon-MM agent port (unified memory) between the CPU's

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_fifo.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// Owner tags, default widths and a small owner helper.
package mem_port_arbiter_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } mem_owner_e;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_PENDING_DEF = 4;

    function automatic mem_owner_e other_owner(input mem_owner_e o);
        return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fifo.sv
// pending_owner_fifo: in-order owner tag per outstanding read.
// Ports: clk, rst, push/push_owner, pop, head, full, empty.
module pending_owner_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  mem_owner_e push_owner,
    input  logic       pop,
    output mem_owner_e head,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    mem_owner_e    slot [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = slot[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slot[wr_ptr] <= push_owner;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one pipelined Avalon-MM agent between
// instr host (i_*, read-only) and data host (d_*, read/write).
// Ports: clk, rst; i_* instr host; d_* data host; m_* agent;
// rsp_error flags a readdatavalid that had no read pending.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_PENDING = MAX_PENDING_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                rsp_error
);
    localparam int BE_W = DATA_W / 8;

    mem_owner_e rr_last;
    mem_owner_e lock_owner;
    mem_owner_e gnt;
    mem_owner_e head;
    logic       lock;
    logic       any_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       rd_room;
    logic       i_elig;
    logic       d_elig;
    logic       accept;

    // Reset gates every combinational path so outputs go idle at once.
    assign pop     = !rst && m_readdatavalid && !fifo_empty;
    assign rd_room = !fifo_full || pop;
    assign i_elig  = i_read && rd_room;
    assign d_elig  = d_write || (d_read && rd_room);

    always_comb begin
        gnt     = OWNER_INSTR;
        any_req = 1'b0;
        if (rst) begin
            any_req = 1'b0;
        end else if (lock) begin
            gnt     = lock_owner;
            any_req = 1'b1;
        end else begin
            unique case (1'b1)
                i_elig && d_elig: begin
                    gnt     = other_owner(rr_last);
                    any_req = 1'b1;
                end
                d_elig && !i_elig: begin
                    gnt     = OWNER_DATA;
                    any_req = 1'b1;
                end
                i_elig && !d_elig: begin
                    gnt     = OWNER_INSTR;
                    any_req = 1'b1;
                end
                default: any_req = 1'b0;
            endcase
        end
    end

    assign m_read = any_req &&
        ((gnt == OWNER_DATA) ? d_read : i_read);
    assign m_write = any_req && (gnt == OWNER_DATA) && d_write;
    assign m_address = (gnt == OWNER_DATA) ? d_address : i_address;
    assign m_writedata = d_writedata;
    assign m_byteenable = (gnt == OWNER_DATA) ?
        d_byteenable : {BE_W{1'b1}};
    assign accept = (m_read || m_write) && !m_waitrequest;

    assign i_waitrequest =
        !(any_req && gnt == OWNER_INSTR) || m_waitrequest;
    assign d_waitrequest =
        !(any_req && gnt == OWNER_DATA) || m_waitrequest;

    assign i_readdata      = m_readdata;
    assign d_readdata      = m_readdata;
    assign i_readdatavalid = pop && (head == OWNER_INSTR);
    assign d_readdatavalid = pop && (head == OWNER_DATA);

    pending_owner_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept && m_read),
        .push_owner (gnt),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_INSTR;
            rr_last    <= OWNER_INSTR;
            rsp_error  <= 1'b0;
        end else begin
            lock <= (m_read || m_write) && m_waitrequest;
            if (m_read || m_write) lock_owner <= gnt;
            if (accept) rr_last <= gnt;
            if (m_readdatavalid && fifo_empty) rsp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue-based
// reference model compared on every negative clock edge.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_address = '0;
    logic          i_read = 1'b0;
    logic          i_waitrequest;
    logic [DW-1:0] i_readdata;
    logic          i_readdatavalid;
    logic [AW-1:0] d_address = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [DW-1:0] d_writedata = '0;
    logic [3:0]    d_byteenable = '0;
    logic          d_waitrequest;
    logic [DW-1:0] d_readdata;
    logic          d_readdatavalid;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [3:0]    m_byteenable;
    logic          m_waitrequest = 1'b0;
    logic [DW-1:0] m_readdata = '0;
    logic          m_readdatavalid = 1'b0;
    logic          rsp_error;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .i_readdatavalid(i_readdatavalid),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act,
                        input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner 0 = instr, 1 = data.
    int   pend[$];
    int   md_rr = 0;
    int   md_lock = 0;
    int   md_who = 0;
    logic md_err = 1'b0;
    int   x_who;
    int   x_head;
    logic x_any, x_pop, x_room, x_ie, x_de, x_rd, x_wr, x_acc;

    always @(negedge clk) begin
        if (rst) begin
            chk1("m_rst_mread", m_read, 1'b0);
            chk1("m_rst_mwrite", m_write, 1'b0);
            chk1("m_rst_iwait", i_waitrequest, 1'b1);
            chk1("m_rst_dwait", d_waitrequest, 1'b1);
            chk1("m_rst_ivld", i_readdatavalid, 1'b0);
            chk1("m_rst_dvld", d_readdatavalid, 1'b0);
            chk1("m_rst_err", rsp_error, 1'b0);
            pend.delete();
            md_rr = 0;
            md_lock = 0;
            md_err = 1'b0;
        end else begin
            x_head = (pend.size() > 0) ? pend[0] : -1;
            x_pop = m_readdatavalid && (pend.size() > 0);
            x_room = (pend.size() < MAXP) || x_pop;
            x_ie = i_read && x_room;
            x_de = d_write || (d_read && x_room);
            x_any = 1'b1;
            x_who = 0;
            if (md_lock != 0) x_who = md_who;
            else if (x_ie && x_de) x_who = 1 - md_rr;
            else if (x_de) x_who = 1;
            else if (x_ie) x_who = 0;
            else x_any = 1'b0;
            x_rd = x_any && ((x_who == 1) ? d_read : i_read);
            x_wr = x_any && (x_who == 1) && d_write;
            chk1("m_mread", m_read, x_rd);
            chk1("m_mwrite", m_write, x_wr);
            if (x_rd || x_wr) begin
                chk("m_addr", m_address,
                    (x_who == 1) ? d_address : i_address);
                chk("m_be", 32'(m_byteenable),
                    (x_who == 1) ? 32'(d_byteenable) : 32'hF);
            end
            if (x_wr) chk("m_wdata", m_writedata, d_writedata);
            chk1("m_iwait", i_waitrequest,
                 !(x_any && x_who == 0) || m_waitrequest);
            chk1("m_dwait", d_waitrequest,
                 !(x_any && x_who == 1) || m_waitrequest);
            chk1("m_ivld", i_readdatavalid, x_pop && x_head == 0);
            chk1("m_dvld", d_readdatavalid, x_pop && x_head == 1);
            if (x_pop && x_head == 0) chk("m_idata", i_readdata, m_readdata);
            if (x_pop && x_head == 1) chk("m_ddata", d_readdata, m_readdata);
            chk1("m_err", rsp_error, md_err);
            x_acc = (x_rd || x_wr) && !m_waitrequest;
            if (m_readdatavalid && pend.size() == 0) md_err = 1'b1;
            if (x_pop) void'(pend.pop_front());
            if (x_acc) md_rr = x_who;
            if (x_acc && x_rd) pend.push_back(x_who);
            md_lock = ((x_rd || x_wr) && m_waitrequest) ? 1 : 0;
            if (x_rd || x_wr) md_who = x_who;
        end
    end

    initial begin
        repeat (2) step();
        chk1("rst_iwait", i_waitrequest, 1'b1);
        chk1("rst_mread", m_read, 1'b0);
        chk1("rst_err", rsp_error, 1'b0);
        rst = 1'b0;

        // 1: simultaneous reads, data wins first tie
        i_read = 1'b1; i_address = 32'h10;
        d_read = 1'b1; d_address = 32'h20;
        #2;
        chk("t1_c0_addr", m_address, 32'h20);
        chk1("t1_c0_dwait", d_waitrequest, 1'b0);
        chk1("t1_c0_iwait", i_waitrequest, 1'b1);
        step(); d_read = 1'b0; #2;
        chk("t1_c1_addr", m_address, 32'h10);
        chk1("t1_c1_iwait", i_waitrequest, 1'b0);
        step(); i_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hAA; #2;
        chk1("t1_dvld", d_readdatavalid, 1'b1);
        chk1("t1_ivld0", i_readdatavalid, 1'b0);
        chk("t1_ddata", d_readdata, 32'hAA);
        step(); m_readdata = 32'hBB; #2;
        chk1("t1_ivld", i_readdatavalid, 1'b1);
        chk1("t1_dvld0", d_readdatavalid, 1'b0);
        chk("t1_idata", i_readdata, 32'hBB);
        step(); m_readdatavalid = 1'b0;

        // 2: stalled write holds the port
        d_write = 1'b1; d_address = 32'h40;
        d_writedata = 32'h1234; d_byteenable = 4'hF;
        i_read = 1'b1; i_address = 32'h50;
        m_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk1("t2_mwrite", m_write, 1'b1);
            chk("t2_addr", m_address, 32'h40);
            chk("t2_wdata", m_writedata, 32'h1234);
            chk1("t2_iwait", i_waitrequest, 1'b1);
            step();
        end
        m_waitrequest = 1'b0; #2;
        chk1("t2_dwait", d_waitrequest, 1'b0);
        step(); d_write = 1'b0; #2;
        chk1("t2_iread", m_read, 1'b1);
        chk("t2_iaddr", m_address, 32'h50);
        chk1("t2_iwait_go", i_waitrequest, 1'b0);
        step(); i_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h55; #2;
        chk1("t2_ivld", i_readdatavalid, 1'b1);
        step(); m_readdatavalid = 1'b0;

        // 3: read throttle at MAXP outstanding
        i_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_address = 32'h100 + 32'(4 * k);
            step();
        end
        i_address = 32'h110; #2;
        chk1("t3_hold_mread", m_read, 1'b0);
        chk1("t3_hold_iwait", i_waitrequest, 1'b1);
        step(); #2;
        chk1("t3_hold2_mread", m_read, 1'b0);
        step();
        m_readdatavalid = 1'b1; m_readdata = 32'h300; #2;
        chk1("t3_free_mread", m_read, 1'b1);
        chk1("t3_free_iwait", i_waitrequest, 1'b0);
        chk1("t3_free_ivld", i_readdatavalid, 1'b1);
        step(); i_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_readdata = 32'h301 + 32'(k); #2;
            chk1("t3_drain_ivld", i_readdatavalid, 1'b1);
            step();
        end
        m_readdatavalid = 1'b0;

        // 4: interleaved owners, responses in order
        d_read = 1'b1; d_address = 32'h200; step();
        d_read = 1'b0; i_read = 1'b1; i_address = 32'h300; step();
        i_read = 1'b0; d_read = 1'b1; d_address = 32'h204; step();
        d_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h1; #2;
        chk1("t4_r1_dvld", d_readdatavalid, 1'b1);
        chk1("t4_r1_ivld", i_readdatavalid, 1'b0);
        step(); m_readdata = 32'h2; #2;
        chk1("t4_r2_ivld", i_readdatavalid, 1'b1);
        chk1("t4_r2_dvld", d_readdatavalid, 1'b0);
        chk("t4_r2_data", i_readdata, 32'h2);
        step(); m_readdata = 32'h3; #2;
        chk1("t4_r3_dvld", d_readdatavalid, 1'b1);
        chk1("t4_r3_ivld", i_readdatavalid, 1'b0);
        step(); m_readdatavalid = 1'b0;

        // 5: stray response
        m_readdatavalid = 1'b1; m_readdata = 32'hDEAD; #2;
        chk1("t5_ivld", i_readdatavalid, 1'b0);
        chk1("t5_dvld", d_readdatavalid, 1'b0);
        chk1("t5_err0", rsp_error, 1'b0);
        step(); m_readdatavalid = 1'b0; #2;
        chk1("t5_err1", rsp_error, 1'b1);
        repeat (3) step();
        chk1("t5_err_sticky", rsp_error, 1'b1);

        // 6: reset with reads in flight
        i_read = 1'b1; i_address = 32'h400; step();
        i_address = 32'h404; step();
        d_write = 1'b1; d_address = 32'h500; #1;
        chk1("t6_pre_mwrite", m_write, 1'b1);
        rst = 1'b1; #1;
        chk1("t6_mread", m_read, 1'b0);
        chk1("t6_mwrite", m_write, 1'b0);
        chk1("t6_iwait", i_waitrequest, 1'b1);
        chk1("t6_dwait", d_waitrequest, 1'b1);
        chk1("t6_err", rsp_error, 1'b0);
        step();
        rst = 1'b0; i_read = 1'b0; d_write = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h77; #2;
        chk1("t6_drop_ivld", i_readdatavalid, 1'b0);
        chk1("t6_drop_dvld", d_readdatavalid, 1'b0);
        step(); #2;
        chk1("t6_drop2_ivld", i_readdatavalid, 1'b0);
        chk1("t6_err1", rsp_error, 1'b1);
        step(); m_readdatavalid = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
